// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : MIPS32 instruction-fetch controller. Owns the PC and the IF/ID
//               register, arbitrates redirect/exception/stall/flush, and
//               detects illegal fetches. Optional jump-to-self halt detection
//               is enabled by defining INST_FETCH_HALT_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          ROM_WORDS  = 256,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    output logic [31:0] Inst_Addr,
    input  logic [31:0] Inst_In,
    output logic [31:0] IFID_Inst,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PC_Plus4,
    output logic        IFID_Valid,
    output logic        fetch_fault,
    output logic        halted
);

    localparam logic [1:0]  c_st_run   = 2'd0;
    localparam logic [1:0]  c_st_halt  = 2'd1;
    localparam logic [1:0]  c_st_fault = 2'd2;
    localparam logic [31:0] c_last_pc  = RESET_PC + 32'(4 * ROM_WORDS) - 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        w_pc_bad;
    logic        w_halt_hit;
    logic        w_ifid_load;
    logic        w_ifid_hold;

    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_bad   = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc > c_last_pc);

`ifdef INST_FETCH_HALT_DETECT_EN
    // A j whose target equals its own PC, seen in IF/ID, is the program's terminal loop.
    assign w_halt_hit = r_ifid_valid
                     && (r_ifid_inst[31:26] == 6'h02)
                     && ({r_ifid_pc4[31:28], r_ifid_inst[25:0], 2'b00} == r_ifid_pc)
                     && !stall && !flush && !exc_req;
`else
    assign w_halt_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run: begin
                if (exc_req) begin
                    w_state_next = c_st_run;
                end else if (w_pc_bad) begin
                    w_state_next = c_st_fault;
                end else if (w_halt_hit) begin
                    w_state_next = c_st_halt;
                end
            end
            c_st_halt: begin
                if (exc_req) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_fault: begin
                w_state_next = c_st_fault;
            end
            default: begin
                w_state_next = c_st_run;
            end
        endcase
    end

    // Output logic
    always_comb begin
        fetch_fault = (r_state == c_st_fault);
`ifdef INST_FETCH_HALT_DETECT_EN
        halted      = (r_state == c_st_halt);
`else
        halted      = 1'b0;
`endif
    end

    // Next-PC arbitration; FAULT ignores everything, HALT only answers exc_req.
    always_comb begin
        w_pc_next = r_pc;
        if (r_state == c_st_run) begin
            if (exc_req) begin
                w_pc_next = EXC_VECTOR;
            end else if (redirect_valid) begin
                w_pc_next = redirect_pc;
            end else if (!stall && !w_pc_bad) begin
                w_pc_next = w_pc_plus4;
            end
        end else if (r_state == c_st_halt) begin
            if (exc_req) begin
                w_pc_next = EXC_VECTOR;
            end
        end
    end

    // IF/ID control: outside RUN the register only ever takes bubbles.
    always_comb begin
        w_ifid_load = 1'b0;
        w_ifid_hold = 1'b0;
        if (r_state == c_st_run) begin
            if (flush || exc_req) begin
                w_ifid_load = 1'b0;
            end else if (stall) begin
                w_ifid_hold = 1'b1;
            end else if (!w_pc_bad) begin
                w_ifid_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid_inst  <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_hold) begin
            r_ifid_inst  <= r_ifid_inst;
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_pc4   <= r_ifid_pc4;
            r_ifid_valid <= r_ifid_valid;
        end else if (w_ifid_load) begin
            r_ifid_inst  <= Inst_In;
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
        end else begin
            r_ifid_inst  <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end
    end

    assign Inst_Addr     = r_pc;
    assign IFID_Inst     = r_ifid_inst;
    assign IFID_PC       = r_ifid_pc;
    assign IFID_PC_Plus4 = r_ifid_pc4;
    assign IFID_Valid    = r_ifid_valid;

endmodule
`default_nettype wire
